// File: rtl/jtvigil_rom_sched.sv
// Graphics-ROM read-port scheduler: two tile-fetch requesters share one SDRAM port,
// each with a single-word cache so repeated reads of one address never touch SDRAM.
module jtvigil_rom_sched #(
  parameter int               AW0     = 17,
  parameter int               AW1     = 18,
  parameter int               AWO     = 22,
  parameter logic [AWO-1:0]   OFFSET0 = '0,
  parameter logic [AWO-1:0]   OFFSET1 = '0,
  parameter int               PRIO    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW0-1:0]  rom0_addr,
  input  logic            rom0_cs,
  output logic [31:0]     rom0_data,
  output logic            rom0_ok,
  input  logic [AW1-1:0]  rom1_addr,
  input  logic            rom1_cs,
  output logic [31:0]     rom1_data,
  output logic            rom1_ok,
  output logic [AWO-1:0]  sdram_addr,
  output logic            sdram_cs,
  input  logic            sdram_ok,
  input  logic [31:0]     sdram_data
);

  localparam int LW     = (AW0 > AW1) ? AW0 : AW1;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t              state_q;
  logic                sdram_cs_q;
  logic [AWO-1:0]      sdram_addr_q;
  logic [DATA_W-1:0]   data0_q, data1_q;
  logic                valid0_q, valid1_q;
  logic [AW0-1:0]      last0_q;
  logic [AW1-1:0]      last1_q;
  logic [LW-1:0]       lat_addr_q;
  logic                rr_q;
  logic                owner_q;

  logic                hit0, hit1;
  logic                need0, need1;
  logic                pick1_d;
  logic [LW-1:0]       req_addr_d;
  logic [AWO-1:0]      sdram_addr_d;

  function automatic logic [AWO-1:0] map_addr(input logic [LW-1:0] a,
                                               input logic [AWO-1:0] off);
    return off + AWO'(a);
  endfunction

  assign hit0  = valid0_q & (rom0_addr == last0_q);
  assign hit1  = valid1_q & (rom1_addr == last1_q);
  assign need0 = rom0_cs & ~hit0;
  assign need1 = rom1_cs & ~hit1;

  // Req 1 wins when it is the only one missing, or on a tie when round-robin favours it.
  assign pick1_d      = need1 & (~need0 | ((PRIO == 0) & rr_q));
  assign req_addr_d   = pick1_d ? LW'(rom1_addr) : LW'(rom0_addr);
  assign sdram_addr_d = pick1_d ? map_addr(req_addr_d, OFFSET1)
                                : map_addr(req_addr_d, OFFSET0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sdram_cs_q   <= 1'b0;
      sdram_addr_q <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
      valid0_q     <= 1'b0;
      valid1_q     <= 1'b0;
      last0_q      <= '0;
      last1_q      <= '0;
      lat_addr_q   <= '0;
      rr_q         <= 1'b0;
      owner_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (need0 | need1) begin
            owner_q      <= pick1_d;
            lat_addr_q   <= req_addr_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_cs_q   <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          // The cache tag comes from the latched address, so a requester changing
          // its address mid-fetch can never get data tagged with the new one.
          if (sdram_ok) begin
            if (owner_q) begin
              data1_q  <= sdram_data;
              last1_q  <= AW1'(lat_addr_q);
              valid1_q <= 1'b1;
            end else begin
              data0_q  <= sdram_data;
              last0_q  <= AW0'(lat_addr_q);
              valid0_q <= 1'b1;
            end
            sdram_cs_q <= 1'b0;
            rr_q       <= ~owner_q;
            state_q    <= GAP;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          sdram_cs_q <= 1'b0;
        end
      endcase
    end
  end

  assign rom0_data  = data0_q;
  assign rom1_data  = data1_q;
  assign rom0_ok    = rom0_cs & hit0;
  assign rom1_ok    = rom1_cs & hit1;
  assign sdram_cs   = sdram_cs_q;
  assign sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtvigil_rom_sched.sv
// Directed bench for jtvigil_rom_sched: a round-robin instance and a fixed-priority
// instance, each with a latency-modelled SDRAM responder and an address scoreboard.
module tb_jtvigil_rom_sched;

  localparam logic [21:0] OFF0  = 22'h000400;
  localparam logic [21:0] OFF1  = 22'h100000;
  localparam int          LAT_A = 5;
  localparam int          LAT_B = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [16:0] r0a_a, r0a_b;
  logic [17:0] r1a_a, r1a_b;
  logic        r0cs_a, r0cs_b, r1cs_a, r1cs_b;
  logic [31:0] r0d_a, r0d_b, r1d_a, r1d_b;
  logic        r0ok_a, r0ok_b, r1ok_a, r1ok_b;
  logic [21:0] sa_a, sa_b;
  logic        scs_a, scs_b, sok_a, sok_b;
  logic [31:0] sd_a, sd_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [21:0] exp_a[$], exp_b[$], log_a[$], log_b[$];

  jtvigil_rom_sched #(.AW0(17), .AW1(18), .AWO(22), .OFFSET0(OFF0), .OFFSET1(OFF1), .PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .rom0_addr(r0a_a), .rom0_cs(r0cs_a), .rom0_data(r0d_a), .rom0_ok(r0ok_a),
    .rom1_addr(r1a_a), .rom1_cs(r1cs_a), .rom1_data(r1d_a), .rom1_ok(r1ok_a),
    .sdram_addr(sa_a), .sdram_cs(scs_a), .sdram_ok(sok_a), .sdram_data(sd_a)
  );

  jtvigil_rom_sched #(.AW0(17), .AW1(18), .AWO(22), .OFFSET0(OFF0), .OFFSET1(OFF1), .PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .rom0_addr(r0a_b), .rom0_cs(r0cs_b), .rom0_data(r0d_b), .rom0_ok(r0ok_b),
    .rom1_addr(r1a_b), .rom1_cs(r1cs_b), .rom1_data(r1d_b), .rom1_ok(r1ok_b),
    .sdram_addr(sa_b), .sdram_cs(scs_b), .sdram_ok(sok_b), .sdram_data(sd_b)
  );

  function automatic logic [31:0] mem(input logic [21:0] a);
    return 32'hA500_0000 ^ {10'd0, a} ^ {a[19:0], 12'd0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SDRAM models: log each new request address, answer after a fixed latency.
  initial begin : resp_a
    int cnt;
    cnt = 0; sok_a = 1'b0; sd_a = '0;
    forever begin
      @(posedge clk); #1;
      if (sok_a) sok_a = 1'b0;
      else if (scs_a) begin
        if (cnt == 0) log_a.push_back(sa_a);
        cnt++;
        if (cnt == LAT_A) begin sok_a = 1'b1; sd_a = mem(sa_a); cnt = 0; end
      end else cnt = 0;
    end
  end

  initial begin : resp_b
    int cnt;
    cnt = 0; sok_b = 1'b0; sd_b = '0;
    forever begin
      @(posedge clk); #1;
      if (sok_b) sok_b = 1'b0;
      else if (scs_b) begin
        if (cnt == 0) log_b.push_back(sa_b);
        cnt++;
        if (cnt == LAT_B) begin sok_b = 1'b1; sd_b = mem(sa_b); cnt = 0; end
      end else cnt = 0;
    end
  end

  // Returns at the falling edge just after the DUT captured sdram_ok.
  task automatic wait_sok(input int k, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (k == 0) ? sok_a : sok_b;
    end
    if (!seen) chk({tag, "_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_scs(input int k, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (k == 0) ? scs_a : scs_b;
    end
    if (!seen) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic pop_chk(input int k, input string tag);
    logic [21:0] e, o;
    o = 'x;
    if (k == 0) begin
      e = exp_a.pop_front();
      if (log_a.size() > 0) o = log_a.pop_front();
    end else begin
      e = exp_b.pop_front();
      if (log_b.size() > 0) o = log_b.pop_front();
    end
    chk(tag, 64'(o), 64'(e));
  endtask

  initial begin
    rst_n  = 1'b0;
    r0a_a  = '0; r0cs_a = 1'b1; r1a_a = '0; r1cs_a = 1'b1;
    r0a_b  = '0; r0cs_b = 1'b0; r1a_b = '0; r1cs_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sdram_cs", 64'(scs_a), 64'd0);
    chk("rst_sdram_addr", 64'(sa_a), 64'd0);
    chk("rst_ok0", 64'(r0ok_a), 64'd0);
    chk("rst_ok1", 64'(r1ok_a), 64'd0);
    chk("rst_data0", 64'(r0d_a), 64'd0);
    chk("rst_data1", 64'(r1d_a), 64'd0);

    // First miss on req 0.
    r1cs_a = 1'b0; r0a_a = 17'h10; r0cs_a = 1'b1;
    exp_a.push_back(OFF0 + 22'h10);
    rst_n = 1'b1;
    wait_scs(0, "first_cs");
    chk("first_saddr", 64'(sa_a), 64'(OFF0 + 22'h10));
    chk("first_ok_pending", 64'(r0ok_a), 64'd0);
    wait_sok(0, "first");
    chk("first_ok", 64'(r0ok_a), 64'd1);
    chk("first_data", 64'(r0d_a), 64'(mem(OFF0 + 22'h10)));
    chk("gap_cs", 64'(scs_a), 64'd0);
    @(negedge clk);
    chk("gap_cs2", 64'(scs_a), 64'd0);
    pop_chk(0, "first_addr");

    // Held address is served from the cache.
    repeat (20) @(negedge clk);
    chk("hold_ok", 64'(r0ok_a), 64'd1);
    chk("hold_nofetch", 64'(log_a.size()), 64'd0);

    // Round-robin: last owner was req 0, so req 1 goes first on the tie.
    r0a_a = 17'h20; r1a_a = 18'h30; r1cs_a = 1'b1;
    exp_a.push_back(OFF1 + 22'h30); exp_a.push_back(OFF0 + 22'h20);
    exp_a.push_back(OFF1 + 22'h31); exp_a.push_back(OFF0 + 22'h21);
    exp_a.push_back(OFF1 + 22'h32); exp_a.push_back(OFF0 + 22'h22);
    for (int i = 0; i < 6; i++) begin
      wait_sok(0, "rr");
      pop_chk(0, "rr_order");
      if (i % 2 == 0) begin
        chk("rr_ok1", 64'(r1ok_a), 64'd1);
        chk("rr_data1", 64'(r1d_a), 64'(mem(OFF1 + {4'd0, r1a_a})));
        if (i < 4) r1a_a = r1a_a + 18'd1;
        else r1cs_a = 1'b0;
      end else begin
        chk("rr_ok0", 64'(r0ok_a), 64'd1);
        chk("rr_data0", 64'(r0d_a), 64'(mem(OFF0 + {5'd0, r0a_a})));
        if (i < 5) r0a_a = r0a_a + 17'd1;
      end
    end

    // Address change during req 1's own fetch.
    r1a_a = 18'h100; r1cs_a = 1'b1;
    exp_a.push_back(OFF1 + 22'h100); exp_a.push_back(OFF1 + 22'h101);
    wait_scs(0, "chg_cs");
    r1a_a = 18'h101;
    wait_sok(0, "chg_first");
    chk("chg_no_ok", 64'(r1ok_a), 64'd0);
    chk("chg_r0_hit", 64'(r0ok_a), 64'd1);
    pop_chk(0, "chg_addr_old");
    wait_sok(0, "chg_second");
    chk("chg_ok", 64'(r1ok_a), 64'd1);
    chk("chg_data", 64'(r1d_a), 64'(mem(OFF1 + 22'h101)));
    pop_chk(0, "chg_addr_new");

    // cs dropped mid-fetch: the word is still cached.
    r0a_a = 17'h40;
    exp_a.push_back(OFF0 + 22'h40);
    wait_scs(0, "drop_cs");
    r0cs_a = 1'b0;
    wait_sok(0, "drop");
    chk("drop_ok_low", 64'(r0ok_a), 64'd0);
    pop_chk(0, "drop_addr");
    r0cs_a = 1'b1;
    #1;
    chk("drop_cached_ok", 64'(r0ok_a), 64'd1);
    chk("drop_cached_data", 64'(r0d_a), 64'(mem(OFF0 + 22'h40)));
    repeat (5) @(negedge clk);
    chk("drop_nofetch", 64'(log_a.size()), 64'd0);

    // Reset while a fetch is in flight.
    r0a_a = 17'h50;
    exp_a.push_back(OFF0 + 22'h50);
    exp_a.push_back(OFF0 + 22'h50);
    exp_a.push_back(OFF1 + 22'h101);
    wait_scs(0, "mid_cs");
    chk("mid_saddr", 64'(sa_a), 64'(OFF0 + 22'h50));
    rst_n = 1'b0;
    #1;
    chk("async_cs", 64'(scs_a), 64'd0);
    chk("async_ok1", 64'(r1ok_a), 64'd0);
    chk("async_data1", 64'(r1d_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_ok0", 64'(r0ok_a), 64'd0);
    chk("post_ok1", 64'(r1ok_a), 64'd0);
    pop_chk(0, "abort_addr");
    wait_sok(0, "refetch0");
    chk("refetch0_ok", 64'(r0ok_a), 64'd1);
    chk("refetch0_data", 64'(r0d_a), 64'(mem(OFF0 + 22'h50)));
    pop_chk(0, "refetch0_addr");
    wait_sok(0, "refetch1");
    chk("refetch1_ok", 64'(r1ok_a), 64'd1);
    chk("refetch1_data", 64'(r1d_a), 64'(mem(OFF1 + 22'h101)));
    pop_chk(0, "refetch1_addr");

    // Fixed priority: req 0 wins even when round-robin would favour req 1.
    r0a_b = 17'h60; r1a_b = 18'h70; r0cs_b = 1'b1; r1cs_b = 1'b1;
    exp_b.push_back(OFF0 + 22'h60);
    exp_b.push_back(OFF0 + 22'h61);
    exp_b.push_back(OFF1 + 22'h70);
    wait_sok(1, "fp0");
    chk("fp0_ok0", 64'(r0ok_b), 64'd1);
    chk("fp0_ok1_low", 64'(r1ok_b), 64'd0);
    pop_chk(1, "fp0_addr");
    r0a_b = 17'h61;
    wait_sok(1, "fp1");
    chk("fp1_ok0", 64'(r0ok_b), 64'd1);
    chk("fp1_data0", 64'(r0d_b), 64'(mem(OFF0 + 22'h61)));
    pop_chk(1, "fp1_addr");
    wait_sok(1, "fp2");
    chk("fp2_ok1", 64'(r1ok_b), 64'd1);
    chk("fp2_data1", 64'(r1d_b), 64'(mem(OFF1 + 22'h70)));
    pop_chk(1, "fp2_addr");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
